uart_tx_arbiter: RTL and testbench

//  Round-robin controller sharing one UART transmitter among N_REQ requesters.

---
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ clients.
// Each grant sends a two-byte frame (tagged header, then payload) and is guarded by a watchdog.
module uart_tx_arbiter #(
  parameter int         N_REQ    = 4,
  parameter int         ID_W     = 2,
  parameter logic [7:0] HDR_BASE = 8'hA0,
  parameter int         TIMEOUT  = 2000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               tx_start,
  output logic [7:0]         tx_byte,
  input  logic               tx_busy,
  input  logic               tx_done,
  output logic               timeout_err
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR_SEND = 3'd1,
    HDR_WAIT = 3'd2,
    DAT_SEND = 3'd3,
    DAT_WAIT = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     grant_r;
  logic [ID_W-1:0]     pick_id;
  logic                pick_vld;
  logic [DATA_W-1:0]   payload_r;
  logic [CNT_W-1:0]    cnt;
  logic [N_REQ-1:0]    ack_r;
  logic                wait_st;
  logic                abort;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (int'(id) == N_REQ - 1) ? '0 : id + 1'b1;
  endfunction

  // Scan downward so the lowest offset from ptr is the final winner.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N_REQ]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'((int'(ptr) + i) % N_REQ);
      end
    end
  end

  assign wait_st = (state == HDR_WAIT) || (state == DAT_WAIT);
  // A tx_done on the expiry cycle still counts as a completed byte.
  assign abort   = wait_st && !tx_done && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (pick_vld) state_nxt = HDR_SEND;
      HDR_SEND: if (!tx_busy) state_nxt = HDR_WAIT;
      HDR_WAIT: begin
        if (tx_done)    state_nxt = DAT_SEND;
        else if (abort) state_nxt = IDLE;
      end
      DAT_SEND: if (!tx_busy) state_nxt = DAT_WAIT;
      DAT_WAIT: begin
        if (tx_done)    state_nxt = IDLE;
        else if (abort) state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr     <= '0;
      grant_r <= '0;
      cnt     <= '0;
      ack_r   <= '0;
    end else begin
      ack_r <= '0;
      if (state == IDLE && pick_vld) grant_r <= pick_id;
      case (state)
        HDR_SEND, DAT_SEND: if (!tx_busy) cnt <= '0;
        HDR_WAIT, DAT_WAIT: cnt <= sat_inc(cnt);
        default:            ;
      endcase
      if (state == DAT_WAIT && tx_done) begin
        ack_r <= N_REQ'(1) << grant_r;
        ptr   <= next_id(grant_r);
      end else if (abort) begin
        ptr   <= next_id(grant_r);
      end
    end
  end

  // Payload is pure data; it is only visible in the DAT_* states.
  always_ff @(posedge clk) begin
    if (state == IDLE && pick_vld) payload_r <= req_data[int'(pick_id) * DATA_W +: DATA_W];
  end

  always_comb begin
    busy        = (state != IDLE);
    grant_id    = busy ? grant_r : '0;
    tx_start    = 1'b0;
    tx_byte     = '0;
    ack         = ack_r;
    timeout_err = abort;
    case (state)
      HDR_SEND: begin
        tx_byte  = HDR_BASE | 8'(grant_r);
        tx_start = !tx_busy;
      end
      HDR_WAIT: tx_byte = HDR_BASE | 8'(grant_r);
      DAT_SEND: begin
        tx_byte  = payload_r;
        tx_start = !tx_busy;
      end
      DAT_WAIT: tx_byte = payload_r;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a frame table plus hand-written watchdog/reset sequences.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        tx_busy;
  logic        tx_done;
  logic        timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_arbiter #(
    .N_REQ(4), .ID_W(2), .HDR_BASE(8'hA0), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .grant_id(grant_id), .busy(busy), .tx_start(tx_start), .tx_byte(tx_byte),
    .tx_busy(tx_busy), .tx_done(tx_done), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  rq;
    logic [31:0] dat;
    int          id;
    logic [7:0]  pay;
    int          stall;
    logic        drop;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_ack"}, 32'(ack), 32'h0);
    chk({name, "_grant"}, 32'(grant_id), 32'h0);
    chk({name, "_busy"}, 32'(busy), 32'h0);
    chk({name, "_txstart"}, 32'(tx_start), 32'h0);
    chk({name, "_txbyte"}, 32'(tx_byte), 32'h0);
    chk({name, "_terr"}, 32'(timeout_err), 32'h0);
  endtask

  task automatic reset_dut();
    reset   = 1'b0;
    req     = '0;
    tx_done = 1'b0;
    tx_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    reset = 1'b1;
  endtask

  // Entered at a negedge in an IDLE cycle; leaves at the negedge of the ack cycle.
  task automatic do_frame(input logic [3:0] r, input logic [31:0] d, input int id,
                          input logic [7:0] pay, input int stall, input logic drop);
    req      = r;
    req_data = d;
    tx_busy  = (stall > 0);
    @(negedge clk);
    chk("grant_busy", 32'(busy), 32'h1);
    chk("grant_id", 32'(grant_id), 32'(id));
    if (drop) begin
      req      = '0;
      req_data = ~d;
    end
    for (int i = 0; i < stall; i++) begin
      chk("stall_txstart", 32'(tx_start), 32'h0);
      chk("stall_terr", 32'(timeout_err), 32'h0);
      @(negedge clk);
    end
    tx_busy = 1'b0;
    #1;
    chk("hdr_txstart", 32'(tx_start), 32'h1);
    chk("hdr_byte", 32'(tx_byte), 32'(8'hA0 | 8'(id)));
    @(negedge clk);
    chk("hdr_wait_txstart", 32'(tx_start), 32'h0);
    chk("hdr_wait_byte", 32'(tx_byte), 32'(8'hA0 | 8'(id)));
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    #1;
    chk("dat_txstart", 32'(tx_start), 32'h1);
    chk("dat_byte", 32'(tx_byte), 32'(pay));
    chk("dat_ack_early", 32'(ack), 32'h0);
    @(negedge clk);
    chk("dat_wait_byte", 32'(tx_byte), 32'(pay));
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("frame_ack", 32'(ack), 32'(4'b0001 << id));
    chk("frame_idle", 32'(busy), 32'h0);
  endtask

  initial begin
    int k;
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    int seen;
    reset    = 1'b0;
    req      = '0;
    req_data = '0;
    tx_busy  = 1'b0;
    tx_done  = 1'b0;

    vecs[0]  = '{1'b1, 4'b0010, 32'h44335A11, 1, 8'h5A, 0, 1'b1};
    vecs[1]  = '{1'b1, 4'b1111, 32'h44332211, 0, 8'h11, 0, 1'b0};
    vecs[2]  = '{1'b0, 4'b1111, 32'h44332211, 1, 8'h22, 0, 1'b0};
    vecs[3]  = '{1'b0, 4'b1111, 32'h44332211, 2, 8'h33, 0, 1'b0};
    vecs[4]  = '{1'b0, 4'b1111, 32'h44332211, 3, 8'h44, 0, 1'b0};
    vecs[5]  = '{1'b0, 4'b0101, 32'h88776655, 0, 8'h55, 0, 1'b0};
    vecs[6]  = '{1'b0, 4'b0101, 32'h88776655, 2, 8'h77, 0, 1'b0};
    vecs[7]  = '{1'b0, 4'b0101, 32'h88776655, 0, 8'h55, 0, 1'b0};
    vecs[8]  = '{1'b0, 4'b0101, 32'h88776655, 2, 8'h77, 0, 1'b0};
    vecs[9]  = '{1'b0, 4'b1001, 32'hDD0000EE, 3, 8'hDD, 0, 1'b0};
    vecs[10] = '{1'b0, 4'b1001, 32'hDD0000EE, 0, 8'hEE, 0, 1'b0};
    vecs[11] = '{1'b0, 4'b0100, 32'h00990000, 2, 8'h99, 3, 1'b1};

    for (int v = 0; v < 12; v++) begin
      if (vecs[v].rst) reset_dut();
      do_frame(vecs[v].rq, vecs[v].dat, vecs[v].id, vecs[v].pay, vecs[v].stall, vecs[v].drop);
    end

    // Long tx_busy stall at grant time must not trip the watchdog.
    reset_dut();
    do_frame(4'b1000, 32'h6B000000, 3, 8'h6B, 10, 1'b0);

    // Watchdog abort: tx_done never returns for id 0, then id 1 is served.
    reset_dut();
    req      = 4'b0011;
    req_data = 32'h0000C3B2;
    @(negedge clk);
    chk("to_txstart", 32'(tx_start), 32'h1);
    seen = 0;
    for (int i = 1; i <= 20 && seen == 0; i++) begin
      @(negedge clk);
      if (timeout_err) seen = i;
      chk("to_no_ack", 32'(ack), 32'h0);
    end
    chk("to_cycle", 32'(seen), 32'd16);
    @(negedge clk);
    chk("to_after_busy", 32'(busy), 32'h0);
    chk("to_after_ack", 32'(ack), 32'h0);
    chk("to_after_terr", 32'(timeout_err), 32'h0);
    do_frame(4'b0011, 32'h0000C3B2, 1, 8'hC3, 0, 1'b0);

    // tx_done on the expiry cycle wins over the watchdog.
    reset_dut();
    req      = 4'b0100;
    req_data = 32'h00E70000;
    @(negedge clk);
    chk("win_txstart", 32'(tx_start), 32'h1);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      chk("win_terr_early", 32'(timeout_err), 32'h0);
    end
    @(negedge clk);
    chk("win_terr_pending", 32'(timeout_err), 32'h1);
    tx_done = 1'b1;
    #1;
    chk("win_terr_masked", 32'(timeout_err), 32'h0);
    @(negedge clk);
    tx_done = 1'b0;
    #1;
    chk("win_dat_txstart", 32'(tx_start), 32'h1);
    chk("win_dat_byte", 32'(tx_byte), 32'hE7);
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("win_ack", 32'(ack), 32'b0100);

    // tx_done while idle is ignored.
    req = '0;
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);
    chk("idle_done_busy", 32'(busy), 32'h0);
    chk("idle_done_ack", 32'(ack), 32'h0);

    // Reset during DAT_WAIT of id 3 aborts the frame and clears the pointer.
    req      = 4'b1000;
    req_data = 32'h5C000000;
    @(negedge clk);
    chk("rst_grant", 32'(grant_id), 32'd3);
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    #1;
    chk("rst_dat_byte", 32'(tx_byte), 32'h5C);
    @(negedge clk);
    reset   = 1'b0;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk_idle_outputs("midrst");
    reset = 1'b1;
    do_frame(4'b1001, 32'h5C0000A5, 0, 8'hA5, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
